hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage 64-bit core.
- Drives the ID/EX register's `stall` (bubble) input.
- Also drives hold/flush controls for PC, IF/ID, EX and EX/MEM.
- Detects load-use hazards, sequences multi-cycle EX operations (MUL/DIV) with a down-counter FSM, and flushes wrong-path instructions on taken branches.

Parameters:
- MC_LATENCY, 4, total cycles a multi-cycle op occupies EX (legal range 2..255).
- CNT_W, 8, width of the internal latency counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs1  in  5  source reg 1 of instruction in ID.
- id_rs2  in  5  source reg 2 of instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  dest reg of instruction in EX (ID/EX output).
- ex_mem_read  in  1  EX instruction is a load.
- ex_multicycle  in  1  EX instruction is a multi-cycle op.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- pc_hold  out  1  PC keeps its value.
- if_id_hold  out  1  IF/ID keeps its contents.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_stall  out  1  ID/EX loads a bubble (to ID_EX.stall).
- ex_hold  out  1  ID/EX and EX unit keep their contents.
- ex_mem_bubble  out  1  EX/MEM loads a bubble.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- States: IDLE, MC_BUSY, MC_LAST.
- Internal counter cnt[CNT_W-1:0].
- Outputs are combinational from state and inputs. No added latency: hazards are flagged in the cycle they appear.
- While rst=1: all outputs are 0. On the clock edge, state<=IDLE and cnt<=0. This holds in every state, including mid multi-cycle op; the op is abandoned.
- Load-use condition LU = ex_mem_read & (ex_rd!=0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). Register x0 never causes a hazard.
- IDLE, priority order:
  1. ex_branch_taken: if_id_flush=1, id_ex_stall=1, no holds; stay IDLE.
  2. ex_multicycle: pc_hold=if_id_hold=ex_hold=ex_mem_bubble=1, id_ex_stall=0. cnt<=MC_LATENCY-2. Next state MC_LAST if MC_LATENCY==2, else MC_BUSY.
  3. LU: pc_hold=if_id_hold=id_ex_stall=1 for exactly this cycle; stay IDLE. The next cycle sees the bubble in EX (ex_mem_read=0), so the stall self-clears.
  4. Otherwise all outputs 0.
- MC_BUSY:
  - pc_hold=if_id_hold=ex_hold=ex_mem_bubble=1; ex_branch_taken and LU are ignored.
  - If cnt==1, next state MC_LAST; else cnt<=cnt-1.
- MC_LAST:
  - Holds released; the op's result enters EX/MEM this cycle.
  - ex_multicycle is ignored (same instruction is still in EX).
  - LU and ex_branch_taken are evaluated as in IDLE.
  - Next state IDLE.
- Timing: a multi-cycle op asserts holds for exactly MC_LATENCY-1 consecutive cycles and releases on cycle MC_LATENCY.
- Back-to-back multi-cycle ops: the second op triggers from IDLE in the cycle after MC_LAST. No gap cycles beyond MC_LAST.
- busy=1 in MC_BUSY and MC_LAST.
- Outputs are never X after the first clock edge with rst=1.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments every cycle pc_hold=1.
  - flush_count increments every cycle if_id_flush=1.
  - Both wrap at 2^32 and clear on rst.
- Undefined: no ports, no counter logic; behaviour is otherwise identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> pc_hold=if_id_hold=id_ex_stall=1 for 1 cycle. Next cycle (ex_mem_read=0) all 0.
- x0 / unused source: ex_rd=0=id_rs1 with load, or id_uses_rs1=0 with a matching reg -> no stall.
- Multi-cycle, MC_LATENCY=4: ex_multicycle=1 held 4 cycles -> holds=1 in cycles 1-3, 0 in cycle 4. busy=1 in cycles 2-4; IDLE in cycle 5.
- Taken branch in IDLE: ex_branch_taken=1 -> if_id_flush=1, id_ex_stall=1, pc_hold=0 for that cycle. With the macro, flush_count 0->1.
- Reset mid-op: rst=1 in MC_BUSY with cnt=2 -> all outputs 0 immediately. After release, busy=0 and a new ex_multicycle restarts a full 4-cycle sequence.
- Priority: ex_branch_taken=1 and LU both true in IDLE -> flush response only, pc_hold=0. With MC_LATENCY=2: 1 hold cycle, then MC_LAST.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle EX sequencing, taken-branch flush; HAZARD_PERF_CNT_EN adds perf counters.
// Latency: outputs are combinational from state and inputs, so hazards are flagged in the cycle they appear.
// Backpressure: holds PC/IF/ID/EX for MC_LATENCY-1 cycles per multi-cycle op; load-use costs one bubble.
module hazard_ctrl #(
    parameter int unsigned MC_LATENCY = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    input  logic       ex_multicycle,
    input  logic       ex_branch_taken,
    output logic       pc_hold,
    output logic       if_id_hold,
    output logic       if_id_flush,
    output logic       id_ex_stall,
    output logic       ex_hold,
    output logic       ex_mem_bubble,
    output logic       busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {IDLE, MC_BUSY, MC_LAST} state_t;

    state_t             state_q, state_d;
    logic   [CNT_W-1:0] cnt_q, cnt_d;
    logic               lu;

    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs1 && (id_rs1 == ex_rd)) || (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_hold       = 1'b0;
        if_id_hold    = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        ex_hold       = 1'b0;
        ex_mem_bubble = 1'b0;
        busy          = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_stall = 1'b1;
                    end else if (ex_multicycle) begin
                        pc_hold       = 1'b1;
                        if_id_hold    = 1'b1;
                        ex_hold       = 1'b1;
                        ex_mem_bubble = 1'b1;
                        cnt_d         = CNT_W'(MC_LATENCY - 2);
                        state_d       = (MC_LATENCY == 2) ? MC_LAST : MC_BUSY;
                    end else if (lu) begin
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_stall = 1'b1;
                    end
                end
                MC_BUSY: begin
                    busy          = 1'b1;
                    pc_hold       = 1'b1;
                    if_id_hold    = 1'b1;
                    ex_hold       = 1'b1;
                    ex_mem_bubble = 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = MC_LAST;
                    else                    cnt_d   = cnt_q - CNT_W'(1);
                end
                MC_LAST: begin
                    // The finished op is still in EX, so its ex_multicycle must not retrigger.
                    busy    = 1'b1;
                    state_d = IDLE;
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_stall = 1'b1;
                    end else if (lu) begin
                        pc_hold     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_stall = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, pc_hold};
        flush_count_d  = flush_count_q + {31'd0, if_id_flush};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MC_LATENCY=4 main instance, MC_LATENCY=2 second instance).
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst, rst_b;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_multicycle, ex_branch_taken;
    logic       pc_hold, if_id_hold, if_id_flush, id_ex_stall, ex_hold, ex_mem_bubble, busy;
    logic       pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_stall_b, ex_hold_b, ex_mem_bubble_b, busy_b;
    logic [6:0] outv, outv_b;
    int         n_vec = 0;
    int         n_bad = 0;
    int         exp_stall = 0;
    int         exp_flush = 0;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count, stall_cycles_b, flush_count_b;
`endif

    always #5 clk = ~clk;

    hazard_ctrl #(.MC_LATENCY(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_multicycle(ex_multicycle),
        .ex_branch_taken(ex_branch_taken),
        .pc_hold(pc_hold), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
        .id_ex_stall(id_ex_stall), .ex_hold(ex_hold), .ex_mem_bubble(ex_mem_bubble), .busy(busy)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    hazard_ctrl #(.MC_LATENCY(2), .CNT_W(8)) u_dut_l2 (
        .clk(clk), .rst(rst_b),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_multicycle(ex_multicycle),
        .ex_branch_taken(ex_branch_taken),
        .pc_hold(pc_hold_b), .if_id_hold(if_id_hold_b), .if_id_flush(if_id_flush_b),
        .id_ex_stall(id_ex_stall_b), .ex_hold(ex_hold_b), .ex_mem_bubble(ex_mem_bubble_b), .busy(busy_b)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cycles(stall_cycles_b), .flush_count(flush_count_b)
`endif
    );

    // Bit order: pc_hold, if_id_hold, if_id_flush, id_ex_stall, ex_hold, ex_mem_bubble, busy
    assign outv   = {pc_hold, if_id_hold, if_id_flush, id_ex_stall, ex_hold, ex_mem_bubble, busy};
    assign outv_b = {pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_stall_b, ex_hold_b, ex_mem_bubble_b, busy_b};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_multicycle = 1'b0; ex_branch_taken = 1'b0;
    endtask

    task automatic set_lu_rs2();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    endtask

    // Check main instance mid-cycle, track expected perf counts, then advance to just after the next edge.
    task automatic step(input string tag, input logic [6:0] exp);
        @(negedge clk);
        chk(tag, {25'd0, outv}, {25'd0, exp});
        if (rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            exp_stall += int'(exp[6]);
            exp_flush += int'(exp[4]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input string tag, input logic [6:0] exp);
        @(negedge clk);
        chk(tag, {25'd0, outv_b}, {25'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        rst_b = 1'b1;
        clr_in();
        set_lu_rs2();
        ex_branch_taken = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_l2", {25'd0, outv_b}, 32'd0);
        step("rst_out", 7'b0000000);
        rst = 1'b0;
        clr_in();

        step("idle", 7'b0000000);
        set_lu_rs2();
        step("lu_rs2", 7'b1101000);
        ex_mem_read = 1'b0;
        step("lu_clear", 7'b0000000);
        clr_in(); ex_mem_read = 1'b1; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        step("x0_no_lu", 7'b0000000);
        clr_in(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
        step("unused_rs1", 7'b0000000);
        id_uses_rs1 = 1'b1;
        step("lu_rs1", 7'b1101000);
        clr_in(); ex_branch_taken = 1'b1;
        step("branch", 7'b0011000);
        set_lu_rs2();
        step("br_over_lu", 7'b0011000);

        clr_in(); ex_multicycle = 1'b1;
        step("mc_c1", 7'b1100110);
        step("mc_c2", 7'b1100111);
        step("mc_c3", 7'b1100111);
        set_lu_rs2();
        step("mc_last_lu", 7'b1101001);
        clr_in();
        step("mc_idle", 7'b0000000);

        ex_multicycle = 1'b1;
        step("b2b_c1", 7'b1100110);
        step("b2b_c2", 7'b1100111);
        ex_branch_taken = 1'b1;
        step("b2b_busy_br", 7'b1100111);
        ex_branch_taken = 1'b0;
        step("b2b_last", 7'b0000001);
        step("b2b2_c1", 7'b1100110);
        step("b2b2_c2", 7'b1100111);
        step("b2b2_c3", 7'b1100111);
        ex_branch_taken = 1'b1;
        step("b2b2_last_br", 7'b0011001);
        clr_in();
        step("b2b_idle", 7'b0000000);

        ex_multicycle = 1'b1;
        step("rmo_c1", 7'b1100110);
        rst = 1'b1;
        step("rmo_rst", 7'b0000000);
        rst = 1'b0;
        step("rmo_re_c1", 7'b1100110);
        step("rmo_re_c2", 7'b1100111);
        step("rmo_re_c3", 7'b1100111);
        step("rmo_re_last", 7'b0000001);
        clr_in();
        step("rmo_idle", 7'b0000000);

`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles", stall_cycles, 32'(exp_stall));
        chk("flush_count", flush_count, 32'(exp_flush));
`endif

        rst_b = 1'b0;
        ex_multicycle = 1'b1;
        step_b("l2_c1", 7'b1100110);
        step_b("l2_last", 7'b0000001);
        step_b("l2_retrig", 7'b1100110);
        clr_in();
        rst_b = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
